// File: rtl/wt_osc.sv
// rtl/wt_osc.sv - wavetable oscillator: phase accumulator, two-word table fetch, linear interpolation
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ena        sample-rate strobe (one-cycle pulse)
//   freq       phase increment per sample, unsigned
//   wmode      1 = table loader owns the RAM; reads are suppressed/aborted
//   ram_addr   RAM read address (held while ram_re=0)
//   ram_re     high while a read address is being driven
//   ram_rdata  RAM read data, valid one cycle after the address
//   audio      signed output sample, held between updates
//   valid      one-cycle pulse when audio updates
//   overrun    one-cycle pulse when ena arrives while busy
module wt_osc #(
  parameter int PW = 32,
  parameter int AW = 13,
  parameter int DW = 16,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ena,
  input  logic [PW-1:0] freq,
  input  logic          wmode,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] audio,
  output logic          valid,
  output logic          overrun
);

  // Product of a 17-bit signed difference and a 9-bit non-negative fraction.
  localparam int PRW = DW + FW + 2;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CAP,
    MUL,
    OUT
  } state_t;

  state_t                 state;
  logic [PW-1:0]          phase;
  logic [AW-1:0]          idx_q;
  logic [FW-1:0]          frac_q;
  logic signed [DW-1:0]   s0;
  logic signed [DW-1:0]   s1;
  logic signed [PRW-1:0]  prod;

  logic signed [DW:0]     diff;
  logic signed [PRW-1:0]  diff_x;
  logic signed [PRW-1:0]  frac_x;
  logic signed [PRW-1:0]  prod_next;
  logic signed [DW-1:0]   interp;

  always_comb begin
    diff      = {s1[DW-1], s1} - {s0[DW-1], s0};
    diff_x    = PRW'(diff);
    frac_x    = PRW'($signed({1'b0, frac_q}));
    prod_next = diff_x * frac_x;
    // Arithmetic shift floors toward -inf; the result always lies between
    // s0 and s1, so truncating back to DW bits cannot overflow.
    interp    = s0 + DW'(prod >>> FW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      phase    <= '0;
      idx_q    <= '0;
      frac_q   <= '0;
      s0       <= '0;
      s1       <= '0;
      prod     <= '0;
      ram_addr <= '0;
      ram_re   <= 1'b0;
      audio    <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;

      // A strobe that lands mid-fetch is dropped without touching phase.
      if (state != IDLE && ena) begin
        overrun <= 1'b1;
      end

      if (state != IDLE && wmode) begin
        // Loader took the RAM mid-fetch: release it and emit silence.
        state  <= IDLE;
        ram_re <= 1'b0;
        audio  <= '0;
        valid  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ena) begin
              phase <= phase + freq;
              if (wmode) begin
                audio <= '0;
                valid <= 1'b1;
              end else begin
                idx_q    <= phase[PW-1 -: AW];
                frac_q   <= phase[PW-AW-1 -: FW];
                ram_addr <= phase[PW-1 -: AW];
                ram_re   <= 1'b1;
                state    <= RD0;
              end
            end
          end
          RD0: begin
            // Natural AW-bit wrap takes the last entry back to entry 0.
            ram_addr <= idx_q + AW'(1);
            state    <= RD1;
          end
          RD1: begin
            s0     <= $signed(ram_rdata);
            ram_re <= 1'b0;
            state  <= CAP;
          end
          CAP: begin
            s1    <= $signed(ram_rdata);
            state <= MUL;
          end
          MUL: begin
            prod  <= prod_next;
            state <= OUT;
          end
          OUT: begin
            audio <= interp;
            valid <= 1'b1;
            state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            ram_re <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wt_osc.sv
// tb/tb_wt_osc.sv - self-checking bench for wt_osc
module tb_wt_osc;

  logic        clk;
  logic        reset_n;
  logic        ena;
  logic [31:0] freq;
  logic        wmode;
  logic [12:0] ram_addr;
  logic        ram_re;
  logic [15:0] ram_rdata;
  logic [15:0] audio;
  logic        valid;
  logic        overrun;

  logic [15:0] mem [8192];

  int pass_cnt;
  int total_cnt;

  wt_osc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .freq      (freq),
    .wmode     (wmode),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .audio     (audio),
    .valid     (valid),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read table RAM.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [31:0] freq;
    logic [15:0] audio;
    logic [12:0] a0;
    logic [12:0] a1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected sample from a phase value: linear interpolation between
  // table[idx] and table[idx+1], floor rounding.
  function automatic logic [15:0] ref_audio(input logic [31:0] ph);
    int idx;
    int fr;
    int a;
    int b;
    int p;
    idx = int'(ph[31:19]);
    fr  = int'(ph[18:11]);
    a   = int'($signed(mem[idx]));
    b   = int'($signed(mem[(idx + 1) % 8192]));
    p   = (b - a) * fr;
    return 16'(a + (p >>> 8));
  endfunction

  // One ena pulse, then observe eight cycles: addresses after edges 0 and 1,
  // latency of the valid pulse (edges after the ena edge), any ram_re.
  task automatic sample(input logic [31:0] f, output int lat, output logic [12:0] a0,
                        output logic [12:0] a1, output bit re_seen);
    @(negedge clk);
    freq = f;
    ena  = 1'b1;
    lat = -1;
    re_seen = 1'b0;
    a0 = '0;
    a1 = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 0) begin
        ena = 1'b0;
        a0  = ram_addr;
      end
      if (n == 1) a1 = ram_addr;
      if (ram_re) re_seen = 1'b1;
      if (valid && lat < 0) lat = n;
    end
  endtask

  initial begin
    int          lat;
    logic [12:0] a0;
    logic [12:0] a1;
    bit          re_seen;
    int          vcnt;
    int          ocnt;
    logic [31:0] ph;
    logic [31:0] f;

    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    ena       = 1'b0;
    freq      = '0;
    wmode     = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 4);
    mem[10] = 16'd100;
    mem[11] = 16'd200;

    tbl[0] = '{32'h0008_0000, 16'd0,   13'd0,  13'd1};
    tbl[1] = '{32'h0008_0000, 16'd4,   13'd1,  13'd2};
    tbl[2] = '{32'h0008_0000, 16'd8,   13'd2,  13'd3};
    tbl[3] = '{32'h0008_0000, 16'd12,  13'd3,  13'd4};
    tbl[4] = '{32'h0034_0000, 16'd16,  13'd4,  13'd5};   // -> idx 10, frac 0x80
    tbl[5] = '{32'hFFFE_0000, 16'd150, 13'd10, 13'd11};  // -> idx 10, frac 0x40
    tbl[6] = '{32'h0000_0000, 16'd125, 13'd10, 13'd11};  // frozen phase
    tbl[7] = '{32'hFFAA_0000, 16'd125, 13'd10, 13'd11};  // -> idx 8191, frac 0x80

    repeat (3) @(negedge clk);
    chk("reset_audio", 32'(audio), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_re",    32'(ram_re), 32'd0);
    chk("reset_addr",  32'(ram_addr), 32'd0);
    chk("reset_ovr",   32'(overrun), 32'd0);
    reset_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      sample(tbl[i].freq, lat, a0, a1, re_seen);
      chk($sformatf("vec%0d_audio", i), 32'(audio), 32'(tbl[i].audio));
      chk($sformatf("vec%0d_lat", i),   32'(lat),   32'd5);
      chk($sformatf("vec%0d_a0", i),    32'(a0),    32'(tbl[i].a0));
      chk($sformatf("vec%0d_a1", i),    32'(a1),    32'(tbl[i].a1));
    end

    // Table wrap: last entry interpolated with entry 0.
    mem[8191] = 16'hFC18;
    mem[0]    = 16'd1000;
    sample(32'h0, lat, a0, a1, re_seen);
    chk("wrap_a0",    32'(a0),    32'd8191);
    chk("wrap_a1",    32'(a1),    32'd0);
    chk("wrap_audio", 32'(audio), 32'd0);

    // wmode raised while the FSM sits in RD1: abort.
    @(negedge clk);
    freq = 32'h0008_0000;
    ena  = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    wmode = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(valid), 32'd1);
    chk("abort_audio", 32'(audio), 32'd0);
    chk("abort_re",    32'(ram_re), 32'd0);
    vcnt = 0;
    re_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (valid) vcnt++;
      if (ram_re) re_seen = 1'b1;
    end
    chk("abort_quiet_valid", 32'(vcnt), 32'd0);
    chk("abort_quiet_re",    32'(re_seen), 32'd0);
    wmode = 1'b0;
    // Phase was advanced before the abort: idx 0, frac 0x80.
    sample(32'h0008_0000, lat, a0, a1, re_seen);
    chk("resume_a0",    32'(a0),    32'd0);
    chk("resume_audio", 32'(audio), 32'd502);

    // ena with wmode=1 in IDLE: silent sample, phase still advances.
    wmode = 1'b1;
    sample(32'h0008_0000, lat, a0, a1, re_seen);
    chk("wm_idle_lat",   32'(lat),     32'd0);
    chk("wm_idle_audio", 32'(audio),   32'd0);
    chk("wm_idle_re",    32'(re_seen), 32'd0);
    wmode = 1'b0;
    sample(32'h0, lat, a0, a1, re_seen);
    chk("wm_after_a0",    32'(a0),    32'd2);
    chk("wm_after_audio", 32'(audio), 32'd10);

    // Two strobes three cycles apart: second is dropped.
    vcnt = 0;
    ocnt = 0;
    @(negedge clk);
    freq = 32'h0008_0000;
    ena  = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (valid) vcnt++;
      if (overrun) ocnt++;
      if (n == 0) ena = 1'b0;
      if (n == 2) ena = 1'b1;
      if (n == 3) ena = 1'b0;
    end
    chk("ovr_valid_cnt", 32'(vcnt),  32'd1);
    chk("ovr_ovr_cnt",   32'(ocnt),  32'd1);
    chk("ovr_audio",     32'(audio), 32'd10);
    sample(32'h0, lat, a0, a1, re_seen);
    chk("ovr_phase_a0",    32'(a0),    32'd3);
    chk("ovr_phase_audio", 32'(audio), 32'd14);

    // Asynchronous reset while in MUL.
    @(negedge clk);
    freq = 32'h0008_0000;
    ena  = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_audio", 32'(audio),    32'd0);
    chk("areset_addr",  32'(ram_addr), 32'd0);
    chk("areset_re",    32'(ram_re),   32'd0);
    chk("areset_valid", 32'(valid),    32'd0);
    chk("areset_ovr",   32'(overrun),  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized samples against the reference model, phase starting at 0.
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    ph = '0;
    for (int i = 0; i < 24; i++) begin
      f = (i % 7 == 3) ? 32'h0 : $urandom;
      sample(f, lat, a0, a1, re_seen);
      chk($sformatf("rnd%0d_a0", i),    32'(a0),    32'(ph[31:19]));
      chk($sformatf("rnd%0d_a1", i),    32'(a1),    32'(13'(ph[31:19] + 13'd1)));
      chk($sformatf("rnd%0d_lat", i),   32'(lat),   32'd5);
      chk($sformatf("rnd%0d_audio", i), 32'(audio), 32'(ref_audio(ph)));
      ph = ph + f;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
